pipeline_sequencer: RTL and testbench
=====================================

// Module: pipeline_sequencer
// PURPOSE
//  Central run/stall/flush controller for the 5-stage MIPS pipeline, sitting beside the ID-stage control unit.
//  Sequences execution (idle, continuous run, single step, drain on HALT) for the debug front-end.
//  Inserts load-use bubbles and flushes IF/ID on branches taken in DE; counts cycles and stalls.
// PARAMETERS
//  CNT_W        32         width of cycle_count and stall_count
//  DRAIN_CYCLES 3          cycles after HALT leaves ID until WB retires it (EX, MEM, WB)
//  HALT_OPCODE  6'b111111  opcode that ends the program
// PORTS
//  clk            in   1      single clock, rising edge
//  rst_n          in   1      asynchronous, active-low reset
//  run_req        in   1      pulse: start continuous execution
//  step_req       in   1      pulse: execute exactly one pipeline cycle
//  stop_req       in   1      pulse: freeze the pipeline (return to IDLE)
//  id_opcode      in   6      opcode of instruction in IF/ID
//  id_rs, id_rt   in   5      source registers of instruction in ID
//  id_uses_rt     in   1      instruction in ID reads rt (R-type, BEQ/BNE, SW)
//  ex_mem_read    in   1      instruction in ID/EX is LW (M_control[1])
//  ex_rt          in   5      destination (rt) of instruction in ID/EX
//  branch_taken   in   1      branch in DE resolved taken this cycle
//  pc_en          out  1      PC load enable
//  ifid_en        out  1      IF/ID write enable
//  ifid_flush     out  1      IF/ID loads NOP on this edge
//  idex_bubble    out  1      ID/EX loads all-zero control fields
//  pipe_en        out  1      ID/EX, EX/MEM, MEM/WB write enable
//  step_done      out  1      one-cycle pulse after a STEP cycle completes
//  halted         out  1      program finished; sticky until reset
//  cycle_count    out  CNT_W  cycles with pipe_en=1, saturating
//  stall_count    out  CNT_W  load-use bubble cycles, saturating
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, drain_cnt=0, counters=0, step_done=0, halted=0; all enables 0.
//  States: IDLE, RUN, STEP, DRAIN, HALTED. Encoded 3 bits.
//   IDLE : all enables 0. run_req -> RUN; else step_req -> STEP (run_req wins if both).
//   RUN  : pipeline active. HALT in ID -> DRAIN; else stop_req -> IDLE. HALT beats stop_req.
//   STEP : pipeline active one cycle -> IDLE with step_done=1 next cycle; HALT in ID -> DRAIN instead.
//          step_req/run_req during STEP ignored.
//   DRAIN: pc_en=0, ifid_en=0, ifid_flush=1, pipe_en=1; drain_cnt counts 1..DRAIN_CYCLES, then -> HALTED.
//          stop_req/step_req/run_req ignored.
//   HALTED: all enables 0, halted=1; only rst_n exits.
//  Active cycle (RUN or STEP, HALT not in ID), enables combinational (Mealy) from state and inputs:
//   load_use = ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
//   load_use=1: pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=1, pipe_en=1; stall_count++.
//               branch_taken ignored this cycle because its operand is still loading.
//   else branch_taken=1: pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=0, pipe_en=1.
//   else: pc_en=ifid_en=pipe_en=1, flush=bubble=0.
//  HALT in ID during an active cycle: pc_en=0, ifid_flush=1, pipe_en=1 (HALT advances into EX).
//   - HALT behind a load-use stall: the stall is served first and HALT re-evaluates next cycle.
//  A STEP cycle that stalls still counts as the one step; step_done still pulses.
//  cycle_count += 1 each cycle pipe_en=1; stall_count += 1 each load_use bubble.
//   - Both counters saturate at all-ones, no wrap.
//  Registered outputs: step_done, halted, counters. All other outputs are combinational.
//  rst_n asserted mid-RUN/DRAIN: immediate IDLE. Counters clear. No partial drain is retained.
// STRUCTURE
//  Shared include mips_defs.vh: opcode constants (LW, SW, BEQ, BNE, R-type, HALT_OPCODE), sequencer state codes.
//  Sub-module load_use_detect (combinational) owns the load_use equation.
//  The hazard-detect function is reused by the forwarding unit.
//  Top holds the FSM, drain counter, step_done/halted registers and saturating counters.
// TESTING
//  1 Reset then idle 5 cycles -> all enables 0, cycle_count=0, halted=0.
//  2 IDLE, step_req 1 cycle, no hazard -> pc_en=pipe_en=1 for exactly 1 cycle.
//    Then step_done=1 for 1 cycle, state IDLE, cycle_count=1.
//  3 RUN, ex_mem_read=1, ex_rt=5, id_rs=5 -> pc_en=0, ifid_en=0, idex_bubble=1 that cycle, stall_count=1.
//    Same with ex_rt=0 -> no stall.
//  4 RUN, branch_taken=1 with no load_use -> ifid_flush=1, pc_en=1.
//    Same cycle with load_use=1 -> ifid_flush=0, idex_bubble=1.
//  5 RUN, id_opcode=6'b111111 with stop_req same cycle -> DRAIN for 3 cycles (pc_en=0, pipe_en=1).
//    Then halted=1; later run_req ignored.
//  6 Counter saturation (CNT_W=4): 20 active cycles -> cycle_count holds 4'hF.
//    Also: rst_n low mid-DRAIN -> IDLE immediately, counters 0.

Source files
------------

// File: rtl/pipeline_sequencer_pkg.sv
// Shared definitions for the pipeline sequencer: halt opcode, FSM state
// encoding and the load-use hazard equation (also used by forwarding).
package pipeline_sequencer_pkg;

    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    // A load in EX writes a register the instruction in ID is about to read.
    // Register 0 never carries a dependency.
    function automatic logic load_use_hazard(
        input logic       mem_read,
        input logic [4:0] rt_dst,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rt
    );
        return mem_read && (rt_dst != 5'd0) &&
               ((rt_dst == rs) || (uses_rt && (rt_dst == rt)));
    endfunction

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Control bundle between the debug front-end / pipeline and the sequencer.
// Handshake: run_req, step_req and stop_req are single-cycle request pulses
// sampled on the rising clock edge; there is no ready back-pressure, a request
// that arrives in a state that ignores it is simply dropped.
interface pipeline_sequencer_if #(
    parameter int CNT_W = 32
);
    import pipeline_sequencer_pkg::*;

    logic             run_req;
    logic             step_req;
    logic             stop_req;
    logic [5:0]       id_opcode;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic             branch_taken;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             pipe_en;
    logic             step_done;
    logic             halted;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] stall_count;
    state_t           seq_state;

    modport master (
        output run_req, step_req, stop_req, id_opcode, id_rs, id_rt,
               id_uses_rt, ex_mem_read, ex_rt, branch_taken,
        input  pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en,
               step_done, halted, cycle_count, stall_count, seq_state
    );

    modport slave (
        input  run_req, step_req, stop_req, id_opcode, id_rs, id_rt,
               id_uses_rt, ex_mem_read, ex_rt, branch_taken,
        output pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en,
               step_done, halted, cycle_count, stall_count, seq_state
    );

endinterface

// File: rtl/pipeline_sequencer_load_use_detect.sv
// Combinational load-use hazard detector for the instruction in ID.
module pipeline_sequencer_load_use_detect
    import pipeline_sequencer_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       load_use
);

    assign load_use = load_use_hazard(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);

endmodule

// File: rtl/pipeline_sequencer.sv
// Run/stall/flush controller for the 5-stage pipeline: sequences idle, run,
// single step and halt drain, inserts load-use bubbles, flushes IF/ID on
// taken branches, and counts active and stalled cycles.
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int         CNT_W        = 32,
    parameter int         DRAIN_CYCLES = 3,
    parameter logic [5:0] HALT_OPCODE  = OP_HALT
) (
    input logic                 clk,
    input logic                 rst_n,
    pipeline_sequencer_if.slave bus
);

    localparam int             DW         = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0]  DRAIN_LAST = DW'(DRAIN_CYCLES);

    state_t           state, next_state;
    logic [DW-1:0]    drain_cnt, drain_nxt;
    logic             load_use, halt_in_id, step_fin, stall_hit;
    logic             pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en;
    logic             step_done, halted;
    logic [CNT_W-1:0] cycle_count, stall_count;

    pipeline_sequencer_load_use_detect u_load_use (
        .ex_mem_read (bus.ex_mem_read),
        .ex_rt       (bus.ex_rt),
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .id_uses_rt  (bus.id_uses_rt),
        .load_use    (load_use)
    );

    assign halt_in_id = (bus.id_opcode == HALT_OPCODE);

    // State and drain counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= next_state;
            drain_cnt <= drain_nxt;
        end
    end

    // Next state and Mealy pipeline enables; a load-use stall is always
    // served before a HALT sitting in ID is allowed to advance.
    always_comb begin
        next_state  = state;
        drain_nxt   = '0;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_en     = 1'b0;
        step_fin    = 1'b0;
        stall_hit   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.run_req)       next_state = ST_RUN;
                else if (bus.step_req) next_state = ST_STEP;
            end
            ST_RUN, ST_STEP: begin
                if (load_use) begin
                    idex_bubble = 1'b1;
                    pipe_en     = 1'b1;
                    stall_hit   = 1'b1;
                    if (state == ST_STEP) begin
                        next_state = ST_IDLE;
                        step_fin   = 1'b1;
                    end else if (bus.stop_req) begin
                        next_state = ST_IDLE;
                    end
                end else if (halt_in_id) begin
                    ifid_flush = 1'b1;
                    pipe_en    = 1'b1;
                    next_state = ST_DRAIN;
                    drain_nxt  = DW'(1);
                end else begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    pipe_en    = 1'b1;
                    ifid_flush = bus.branch_taken;
                    if (state == ST_STEP) begin
                        next_state = ST_IDLE;
                        step_fin   = 1'b1;
                    end else if (bus.stop_req) begin
                        next_state = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                ifid_flush = 1'b1;
                pipe_en    = 1'b1;
                if (drain_cnt == DRAIN_LAST) next_state = ST_HALTED;
                else                         drain_nxt  = drain_cnt + DW'(1);
            end
            ST_HALTED: begin
                next_state = ST_HALTED;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Step completion pulse and sticky halted flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_done <= 1'b0;
            halted    <= 1'b0;
        end else begin
            step_done <= step_fin;
            halted    <= (next_state == ST_HALTED);
        end
    end

    // Saturating cycle and stall counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
            stall_count <= '0;
        end else begin
            if (pipe_en && (cycle_count != '1))   cycle_count <= cycle_count + 1'b1;
            if (stall_hit && (stall_count != '1)) stall_count <= stall_count + 1'b1;
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.pipe_en     = pipe_en;
    assign bus.step_done   = step_done;
    assign bus.halted      = halted;
    assign bus.cycle_count = cycle_count;
    assign bus.stall_count = stall_count;
    assign bus.seq_state   = state;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: main instance at CNT_W=32 plus a
// CNT_W=4 instance that free-runs to show counter saturation.
module tb_pipeline_sequencer;
    import pipeline_sequencer_pkg::*;

    localparam logic [4:0] EN_OFF   = 5'b00000; // {pc,ifid,flush,bubble,pipe}
    localparam logic [4:0] EN_RUN   = 5'b11001;
    localparam logic [4:0] EN_STALL = 5'b00011;
    localparam logic [4:0] EN_BR    = 5'b11101;
    localparam logic [4:0] EN_HALT  = 5'b00101;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   exp_cyc  = 0;
    int   exp_stall = 0;
    logic [4:0] exp_q[$];

    pipeline_sequencer_if #(.CNT_W(32)) m ();
    pipeline_sequencer_if #(.CNT_W(4))  s ();

    pipeline_sequencer #(.CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(m));
    pipeline_sequencer #(.CNT_W(4))  dut_sat (.clk(clk), .rst_n(rst_n), .bus(s));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: expected enables go into the scoreboard when the inputs are
    // driven and are popped against the settled DUT outputs.
    task automatic cyc(input logic [4:0] exp_en, input string tag);
        logic [4:0] e;
        exp_q.push_back(exp_en);
        if (exp_en[0]) exp_cyc++;
        if (exp_en == EN_STALL) exp_stall++;
        #1;
        e = exp_q.pop_front();
        check(tag, {27'd0, m.pc_en, m.ifid_en, m.ifid_flush, m.idex_bubble, m.pipe_en},
              {27'd0, e});
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        m.run_req = 0; m.step_req = 0; m.stop_req = 0; m.id_opcode = 6'd0;
        m.id_rs = 0; m.id_rt = 0; m.id_uses_rt = 0; m.ex_mem_read = 0;
        m.ex_rt = 0; m.branch_taken = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        s.run_req = 0; s.step_req = 0; s.stop_req = 0; s.id_opcode = 6'd0;
        s.id_rs = 0; s.id_rt = 0; s.id_uses_rt = 0; s.ex_mem_read = 0;
        s.ex_rt = 0; s.branch_taken = 0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_en", {27'd0, m.pc_en, m.ifid_en, m.ifid_flush, m.idex_bubble, m.pipe_en}, 32'd0);
        check("rst_state", 32'(m.seq_state), 32'(ST_IDLE));
        check("rst_cycles", m.cycle_count, 32'd0);
        check("rst_halted", {31'd0, m.halted}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: idle five cycles; saturating instance started on the first one
        for (int i = 0; i < 5; i++) begin
            s.run_req = (i == 0);
            cyc(EN_OFF, "idle");
        end
        s.run_req = 0;
        check("idle_cycles", m.cycle_count, 32'd0);
        check("idle_halted", {31'd0, m.halted}, 32'd0);
        check("sat_partial", {28'd0, s.cycle_count}, 32'd4);

        // 2: single step
        m.step_req = 1; cyc(EN_OFF, "step_req");
        m.step_req = 0; cyc(EN_RUN, "step_active");
        check("step_done_hi", {31'd0, m.step_done}, 32'd1);
        check("step_state", 32'(m.seq_state), 32'(ST_IDLE));
        check("step_cycles", m.cycle_count, 32'd1);
        cyc(EN_OFF, "after_step");
        check("step_done_lo", {31'd0, m.step_done}, 32'd0);

        // 3/4: run with load-use and branch patterns
        m.run_req = 1; cyc(EN_OFF, "run_req");
        m.run_req = 0; cyc(EN_RUN, "run_free");
        m.ex_mem_read = 1; m.ex_rt = 5; m.id_rs = 5;
        cyc(EN_STALL, "lu_rs");
        check("stall_one", m.stall_count, 32'd1);
        m.ex_rt = 0; m.id_rs = 0;
        cyc(EN_RUN, "lu_r0");
        m.ex_rt = 7; m.id_rt = 7; m.id_rs = 3; m.id_uses_rt = 1;
        cyc(EN_STALL, "lu_rt");
        m.id_uses_rt = 0;
        cyc(EN_RUN, "lu_rt_unused");
        m.ex_mem_read = 0; m.ex_rt = 0; m.id_rt = 0; m.id_rs = 0; m.branch_taken = 1;
        cyc(EN_BR, "branch");
        m.ex_mem_read = 1; m.ex_rt = 5; m.id_rs = 5;
        cyc(EN_STALL, "branch_stall");
        clear_inputs();
        check("stall_three", m.stall_count, 32'(exp_stall));
        m.stop_req = 1; cyc(EN_RUN, "stop_cycle");
        m.stop_req = 0; cyc(EN_OFF, "stopped");
        check("stop_state", 32'(m.seq_state), 32'(ST_IDLE));
        check("run_cycles", m.cycle_count, 32'(exp_cyc));

        // A step that stalls still completes the step
        m.step_req = 1; cyc(EN_OFF, "step_req2");
        m.step_req = 0; m.ex_mem_read = 1; m.ex_rt = 4; m.id_rt = 4; m.id_uses_rt = 1;
        cyc(EN_STALL, "step_stall");
        clear_inputs();
        check("step_stall_done", {31'd0, m.step_done}, 32'd1);
        check("step_stall_state", 32'(m.seq_state), 32'(ST_IDLE));
        check("step_stall_cnt", m.stall_count, 32'(exp_stall));

        // 6: saturating instance has run well over 15 active cycles
        check("sat_cycles", {28'd0, s.cycle_count}, 32'hF);

        // 5: HALT behind a stall, then HALT beats stop_req, drain, halted
        m.run_req = 1; cyc(EN_OFF, "run_req2");
        m.run_req = 0; m.id_opcode = OP_HALT; m.ex_mem_read = 1; m.ex_rt = 9; m.id_rs = 9;
        cyc(EN_STALL, "halt_behind_stall");
        m.ex_mem_read = 0; m.ex_rt = 0; m.id_rs = 0; m.stop_req = 1;
        cyc(EN_HALT, "halt_vs_stop");
        clear_inputs();
        check("drain_state", 32'(m.seq_state), 32'(ST_DRAIN));
        cyc(EN_HALT, "drain1");
        m.run_req = 1; m.step_req = 1; m.stop_req = 1;
        cyc(EN_HALT, "drain2");
        clear_inputs();
        cyc(EN_HALT, "drain3");
        check("halted_state", 32'(m.seq_state), 32'(ST_HALTED));
        check("halted_flag", {31'd0, m.halted}, 32'd1);
        m.run_req = 1; cyc(EN_OFF, "halted_run");
        m.run_req = 0; cyc(EN_OFF, "halted_idle");
        check("halted_sticky", {31'd0, m.halted}, 32'd1);
        check("halted_state2", 32'(m.seq_state), 32'(ST_HALTED));
        check("halt_cycles", m.cycle_count, 32'(exp_cyc));

        // Reset mid-DRAIN
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cyc = 0; exp_stall = 0;
        m.run_req = 1; cyc(EN_OFF, "run_req3");
        m.run_req = 0; m.id_opcode = OP_HALT;
        cyc(EN_HALT, "halt3");
        m.id_opcode = 6'd0;
        cyc(EN_HALT, "drain_a");
        check("pre_rst_state", 32'(m.seq_state), 32'(ST_DRAIN));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_state", 32'(m.seq_state), 32'(ST_IDLE));
        check("mid_rst_en", {27'd0, m.pc_en, m.ifid_en, m.ifid_flush, m.idex_bubble, m.pipe_en}, 32'd0);
        check("mid_rst_cycles", m.cycle_count, 32'd0);
        check("mid_rst_halted", {31'd0, m.halted}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_state", 32'(m.seq_state), 32'(ST_IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
